// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - instruction prefetch queue with two-word instruction assembly
//
// Prefetches 16-bit program words into a small circular buffer and presents
// complete instructions (one or two words) to a valid/ready consumer.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   pm_addr, pm_rd_en          program memory read request (pm_addr = fetch pc)
//   pm_data                    read data, valid the cycle after pm_rd_en
//   out_valid, out_ready       instruction handshake with the consumer
//   out_instr, out_operand     first word, second word (0 for single-word)
//   out_two_word, out_pc       instruction length flag, address of out_instr
//   redirect, redirect_pc      flush the queue and restart fetch at redirect_pc
module fetch_queue_unit #(
    parameter int PC_WIDTH    = 14,
    parameter int DEPTH       = 4,
    parameter int TWO_WORD_EN = 1
) (
    input  logic                clk,
    input  logic                reset,
    output logic [PC_WIDTH-1:0] pm_addr,
    output logic                pm_rd_en,
    input  logic [15:0]         pm_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [15:0]         out_instr,
    output logic [15:0]         out_operand,
    output logic                out_two_word,
    output logic [PC_WIDTH-1:0] out_pc,
    input  logic                redirect,
    input  logic [PC_WIDTH-1:0] redirect_pc
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int OW = CW + 1;

    logic [15:0]         buf_data [DEPTH];
    logic [PC_WIDTH-1:0] buf_pc   [DEPTH];
    logic [AW-1:0]       head;
    logic [AW-1:0]       tail;
    logic [CW-1:0]       count;
    logic [PC_WIDTH-1:0] fetch_pc;
    logic                inflight;
    logic [PC_WIDTH-1:0] inflight_pc;

    logic [AW-1:0] head_next;
    logic [OW-1:0] occupancy;
    logic          head_two;
    logic          head_ok;
    logic          xfer;
    logic [1:0]    pop_cnt;

    function automatic logic is_two_word(input logic [15:0] w);
        logic lds, sts, jmp, call;
        lds  = (w[15:9] == 7'b1001000) && (w[3:0] == 4'b0000);
        sts  = (w[15:9] == 7'b1001001) && (w[3:0] == 4'b0000);
        jmp  = (w[15:9] == 7'b1001010) && (w[3:1] == 3'b110);
        call = (w[15:9] == 7'b1001010) && (w[3:1] == 3'b111);
        return lds || sts || jmp || call;
    endfunction

    assign head_next = head + AW'(1);
    assign head_two  = (TWO_WORD_EN != 0) && is_two_word(buf_data[head]);

    // A two-word instruction is only presentable once its operand has arrived.
    assign head_ok = head_two ? (count >= CW'(2)) : (count != '0);

    // Reads already in flight reserve a slot so the buffer can never overflow.
    assign occupancy = OW'(count) + OW'(inflight);
    assign pm_rd_en  = !reset && !redirect && (occupancy < OW'(DEPTH));
    assign pm_addr   = fetch_pc;

    assign out_valid    = head_ok && !redirect;
    assign out_instr    = head_ok ? buf_data[head] : 16'h0000;
    assign out_operand  = (head_ok && head_two) ? buf_data[head_next] : 16'h0000;
    assign out_two_word = head_ok && head_two;
    assign out_pc       = head_ok ? buf_pc[head] : '0;

    assign xfer    = out_valid && out_ready;
    assign pop_cnt = xfer ? (head_two ? 2'd2 : 2'd1) : 2'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            fetch_pc    <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect) begin
            // Clearing inflight drops the word returning this cycle or next.
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            fetch_pc    <= redirect_pc;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            if (pm_rd_en) begin
                fetch_pc <= fetch_pc + PC_WIDTH'(1);
            end
            inflight    <= pm_rd_en;
            inflight_pc <= fetch_pc;
            if (inflight) begin
                tail <= tail + AW'(1);
            end
            head  <= head + AW'(pop_cnt);
            count <= count + CW'(inflight) - CW'(pop_cnt);
        end
    end

    // Storage needs no reset: nothing is presented while count is zero.
    always_ff @(posedge clk) begin
        if (!reset && !redirect && inflight) begin
            buf_data[tail] <= pm_data;
            buf_pc[tail]   <= inflight_pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb/tb_fetch_queue_unit.sv - self-checking bench for fetch_queue_unit
module tb_fetch_queue_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        out_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [13:0] redirect_pc = 14'h0;

    logic [13:0] pm_addr0, pm_addr1;
    logic        pm_rd_en0, pm_rd_en1;
    logic [15:0] pm_data0, pm_data1;
    logic        out_valid0, out_valid1;
    logic [15:0] out_instr0, out_instr1;
    logic [15:0] out_operand0, out_operand1;
    logic        out_two_word0, out_two_word1;
    logic [13:0] out_pc0, out_pc1;

    logic [15:0] mem [0:16383];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_queue_unit #(.PC_WIDTH(14), .DEPTH(4), .TWO_WORD_EN(1)) dut0 (
        .clk(clk), .reset(reset),
        .pm_addr(pm_addr0), .pm_rd_en(pm_rd_en0), .pm_data(pm_data0),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_instr(out_instr0), .out_operand(out_operand0),
        .out_two_word(out_two_word0), .out_pc(out_pc0),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    fetch_queue_unit #(.PC_WIDTH(14), .DEPTH(4), .TWO_WORD_EN(0)) dut1 (
        .clk(clk), .reset(reset),
        .pm_addr(pm_addr1), .pm_rd_en(pm_rd_en1), .pm_data(pm_data1),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_instr(out_instr1), .out_operand(out_operand1),
        .out_two_word(out_two_word1), .out_pc(out_pc1),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    // Synchronous program memory: data is meaningful only after a read request.
    always @(posedge clk) pm_data0 <= pm_rd_en0 ? mem[pm_addr0] : 16'hDEAD;
    always @(posedge clk) pm_data1 <= pm_rd_en1 ? mem[pm_addr1] : 16'hDEAD;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic is2(input logic [15:0] w);
        return (w ==? 16'b1001_000?_????_0000) || (w ==? 16'b1001_001?_????_0000) ||
               (w ==? 16'b1001_010?_????_110?) || (w ==? 16'b1001_010?_????_111?);
    endfunction

    typedef struct {
        logic        rdy;
        logic        rdr;
        logic [13:0] rpc;
        logic        v;
        logic [15:0] instr;
        logic [15:0] opnd;
        logic        two;
        logic [13:0] pc;
        logic        rd;
        logic [13:0] addr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rdy, input logic rdr, input logic [13:0] rpc,
                                input logic v, input logic [15:0] instr, input logic [15:0] opnd,
                                input logic two, input logic [13:0] pc, input logic rd,
                                input logic [13:0] addr);
        vec_t t;
        t.rdy = rdy; t.rdr = rdr; t.rpc = rpc; t.v = v; t.instr = instr;
        t.opnd = opnd; t.two = two; t.pc = pc; t.rd = rd; t.addr = addr;
        return t;
    endfunction

    // Stream-level reference model for the randomized phase.
    logic [13:0] mpc [2];
    logic        hold [2];
    logic [15:0] prev_instr [2];
    logic [13:0] prev_pc [2];
    int          xfers [2];

    task automatic model_step(input int k, input logic v, input logic [15:0] ins,
                              input logic [15:0] opd, input logic two,
                              input logic [13:0] pc, input logic rd);
        logic [15:0] ei, eo;
        logic        et;
        if (hold[k] && !redirect) begin
            check($sformatf("rnd%0d_hold_valid", k), v, 1'b1);
            check($sformatf("rnd%0d_hold_instr", k), ins, prev_instr[k]);
            check($sformatf("rnd%0d_hold_pc", k), pc, prev_pc[k]);
        end
        if (redirect) begin
            check($sformatf("rnd%0d_redirect_rd_en", k), rd, 1'b0);
            check($sformatf("rnd%0d_redirect_valid", k), v, 1'b0);
            mpc[k] = redirect_pc;
        end else if (v && out_ready) begin
            ei = mem[mpc[k]];
            et = (k == 0) && is2(ei);
            eo = et ? mem[mpc[k] + 14'd1] : 16'h0000;
            check($sformatf("rnd%0d_pc", k), pc, mpc[k]);
            check($sformatf("rnd%0d_instr", k), ins, ei);
            check($sformatf("rnd%0d_two", k), two, et);
            check($sformatf("rnd%0d_operand", k), opd, eo);
            mpc[k] = mpc[k] + (et ? 14'd2 : 14'd1);
            xfers[k]++;
        end
        hold[k]       = v && !out_ready && !redirect;
        prev_instr[k] = ins;
        prev_pc[k]    = pc;
    endtask

    initial begin
        logic got;
        for (int i = 0; i < 16384; i++) mem[i] = 16'(i + 16'h0100);
        mem[4] = 16'h940C;
        mem[5] = 16'h1234;

        // Cycle-by-cycle expectations from reset release (c1 onward).
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 0, 14'h0000, 1, 14'h0000));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 0, 14'h0000, 1, 14'h0001));
        vecs.push_back(mk(1, 0, 0, 1, 16'h0100, 0, 0, 14'h0000, 1, 14'h0002));
        vecs.push_back(mk(1, 0, 0, 1, 16'h0101, 0, 0, 14'h0001, 1, 14'h0003));
        vecs.push_back(mk(1, 0, 0, 1, 16'h0102, 0, 0, 14'h0002, 1, 14'h0004));
        vecs.push_back(mk(1, 0, 0, 1, 16'h0103, 0, 0, 14'h0003, 1, 14'h0005));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 0, 14'h0000, 1, 14'h0006));
        vecs.push_back(mk(1, 0, 0, 1, 16'h940C, 16'h1234, 1, 14'h0004, 1, 14'h0007));
        vecs.push_back(mk(0, 0, 0, 1, 16'h0106, 0, 0, 14'h0006, 1, 14'h0008));
        vecs.push_back(mk(0, 0, 0, 1, 16'h0106, 0, 0, 14'h0006, 1, 14'h0009));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0, 0, 0, 1, 16'h0106, 0, 0, 14'h0006, 0, 14'h000A));
        vecs.push_back(mk(1, 0, 0, 1, 16'h0106, 0, 0, 14'h0006, 0, 14'h000A));
        vecs.push_back(mk(1, 0, 0, 1, 16'h0107, 0, 0, 14'h0007, 1, 14'h000A));
        vecs.push_back(mk(1, 0, 0, 1, 16'h0108, 0, 0, 14'h0008, 1, 14'h000B));
        vecs.push_back(mk(1, 0, 0, 1, 16'h0109, 0, 0, 14'h0009, 1, 14'h000C));
        vecs.push_back(mk(1, 1, 14'h0200, 0, 16'h0000, 0, 0, 14'h0000, 0, 14'h000D));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 0, 14'h0000, 1, 14'h0200));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 0, 14'h0000, 1, 14'h0201));
        vecs.push_back(mk(1, 0, 0, 1, 16'h0300, 0, 0, 14'h0200, 1, 14'h0202));
        vecs.push_back(mk(1, 1, 14'h3FFE, 0, 16'h0000, 0, 0, 14'h0000, 0, 14'h0203));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 0, 14'h0000, 1, 14'h3FFE));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 0, 14'h0000, 1, 14'h3FFF));
        vecs.push_back(mk(1, 0, 0, 1, 16'h40FE, 0, 0, 14'h3FFE, 1, 14'h0000));
        vecs.push_back(mk(1, 0, 0, 1, 16'h40FF, 0, 0, 14'h3FFF, 1, 14'h0001));
        vecs.push_back(mk(1, 0, 0, 1, 16'h0100, 0, 0, 14'h0000, 1, 14'h0002));

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_rd_en0", pm_rd_en0, 1'b0);
        check("rst_rd_en1", pm_rd_en1, 1'b0);
        check("rst_valid0", out_valid0, 1'b0);
        check("rst_addr0", pm_addr0, 14'h0);
        check("rst_instr0", out_instr0, 16'h0);
        check("rst_operand0", out_operand0, 16'h0);
        check("rst_pc0", out_pc0, 14'h0);
        check("rst_two0", out_two_word0, 1'b0);

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            if (i > 0) @(negedge clk);
            out_ready   = vecs[i].rdy;
            redirect    = vecs[i].rdr;
            redirect_pc = vecs[i].rpc;
            #1;
            check($sformatf("vec%0d_valid", i), out_valid0, vecs[i].v);
            check($sformatf("vec%0d_rd_en", i), pm_rd_en0, vecs[i].rd);
            check($sformatf("vec%0d_addr", i), pm_addr0, vecs[i].addr);
            if (vecs[i].v) begin
                check($sformatf("vec%0d_instr", i), out_instr0, vecs[i].instr);
                check($sformatf("vec%0d_operand", i), out_operand0, vecs[i].opnd);
                check($sformatf("vec%0d_two", i), out_two_word0, vecs[i].two);
                check($sformatf("vec%0d_pc", i), out_pc0, vecs[i].pc);
            end
        end

        // JMP at address 0 seen by both variants of the two-word detection.
        @(negedge clk);
        mem[0]      = 16'h940C;
        mem[1]      = 16'h5555;
        out_ready   = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 14'h0;
        @(negedge clk);
        redirect = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            #1;
            if (out_valid0 && out_valid1) got = 1'b1;
            else @(negedge clk);
        end
        check("tw_wait_valid", got, 1'b1);
        check("tw_en1_instr", out_instr0, 16'h940C);
        check("tw_en1_two", out_two_word0, 1'b1);
        check("tw_en1_operand", out_operand0, 16'h5555);
        check("tw_en0_instr", out_instr1, 16'h940C);
        check("tw_en0_two", out_two_word1, 1'b0);
        check("tw_en0_operand", out_operand1, 16'h0);
        check("tw_en0_pc", out_pc1, 14'h0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check("tw_en1_next_pc", out_pc0, 14'h0002);
        check("tw_en1_next_instr", out_instr0, 16'h0102);
        check("tw_en0_next_pc", out_pc1, 14'h0001);
        check("tw_en0_next_instr", out_instr1, 16'h5555);
        check("tw_en0_next_valid", out_valid1, 1'b1);

        // Asynchronous reset in the middle of a cycle with a full buffer.
        @(negedge clk);
        out_ready = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("midrst_valid0", out_valid0, 1'b0);
        check("midrst_valid1", out_valid1, 1'b0);
        check("midrst_rd_en0", pm_rd_en0, 1'b0);
        check("midrst_addr0", pm_addr0, 14'h0);
        check("midrst_instr0", out_instr0, 16'h0);

        // Randomized stream against the reference model.
        for (int i = 0; i < 16384; i++) begin
            logic [15:0] w;
            logic [31:0] r;
            r = $urandom;
            w = r[15:0];
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 3))
                    0: w = 16'h9000 | {7'b0, r[20:16], 4'b0};
                    1: w = 16'h9200 | {7'b0, r[20:16], 4'b0};
                    2: w = 16'h940C | {7'b0, r[20:16], 3'b0, r[21]};
                    default: w = 16'h940E | {7'b0, r[20:16], 3'b0, r[21]};
                endcase
            end
            mem[i] = w;
        end
        for (int k = 0; k < 2; k++) begin
            mpc[k] = 14'h0; hold[k] = 1'b0; xfers[k] = 0;
            prev_instr[k] = 16'h0; prev_pc[k] = 14'h0;
        end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (c > 0) @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            redirect  = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 3) == 0) redirect_pc = 14'h3FFC + 14'($urandom_range(0, 3));
            else redirect_pc = 14'($urandom);
            #1;
            model_step(0, out_valid0, out_instr0, out_operand0, out_two_word0, out_pc0, pm_rd_en0);
            model_step(1, out_valid1, out_instr1, out_operand1, out_two_word1, out_pc1, pm_rd_en1);
        end
        check("rnd0_throughput", xfers[0] > 500, 1'b1);
        check("rnd1_throughput", xfers[1] > 500, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
